// File: rtl/upscale2x_interp.sv
// upscale2x_interp
//   2x video upscaler placed between a SRC_W x SRC_H frame buffer and the VGA
//   output path. Supports nearest-neighbour and bilinear modes. The VGA x/y
//   coordinates drive the frame-buffer read address combinationally. Source
//   pixels come back one clock later. One horizontally interpolated output
//   line is buffered so the following odd line can be blended vertically.
//   Every pixel leaves exactly two clocks after its x/y/de.
//
// Ports
//   clk_25MHz  in   pixel clock
//   reset      in   asynchronous, active-high
//   mode       in   0 = nearest, 1 = bilinear; latched at frame start (de, x=0, y=0)
//   de         in   VGA display enable, aligned with x_pixel/y_pixel
//   x_pixel    in   VGA column (10 bits)
//   y_pixel    in   VGA row (10 bits)
//   src_addr   out  frame-buffer read address, row*SRC_W + col (combinational)
//   src_data   in   frame-buffer data, valid one clock after src_addr
//   pix_out    out  upscaled pixel (0 when blanked or outside the window)
//   pix_de     out  de delayed to match pix_out
module upscale2x_interp #(
  parameter  int SRC_W = 320,
  parameter  int SRC_H = 240,
  parameter  int CH    = 3,
  parameter  int CW    = 4,
  localparam int PW    = CH * CW,
  localparam int AW    = $clog2(SRC_W * SRC_H)
) (
  input  logic          clk_25MHz,
  input  logic          reset,
  input  logic          mode,
  input  logic          de,
  input  logic [9:0]    x_pixel,
  input  logic [9:0]    y_pixel,
  output logic [AW-1:0] src_addr,
  input  logic [PW-1:0] src_data,
  output logic [PW-1:0] pix_out,
  output logic          pix_de
);

  localparam int DST_W = 2 * SRC_W;
  localparam int DST_H = 2 * SRC_H;
  localparam int XW    = $clog2(DST_W);

  // Per-channel rounded average; the CW+1-bit sum cannot overflow.
  function automatic logic [PW-1:0] avg2(input logic [PW-1:0] a, input logic [PW-1:0] b);
    logic [PW-1:0] r;
    logic [CW:0]   s;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      s = {1'b0, a[c*CW +: CW]} + {1'b0, b[c*CW +: CW]} + {{CW{1'b0}}, 1'b1};
      r[c*CW +: CW] = s[CW:1];
    end
    return r;
  endfunction

  logic [8:0]    sx, sy;
  logic [9:0]    nx, ny, row, col;
  logic          in_win, frame_start, mode_d;
  logic [XW-1:0] lb_raddr;

  logic          mode_q;
  logic          de_p1_q, win_p1_q, xodd_p1_q, yodd_p1_q, mode_p1_q;
  logic [XW-1:0] x_p1_q;
  logic [PW-1:0] held_q, held_d;
  logic [PW-1:0] pix_out_q, pix_out_d;
  logic          pix_de_q;

  logic [PW-1:0] lbuf [DST_W];
  logic [PW-1:0] lb_rd_q;
  logic [PW-1:0] h_val, v_val;
  logic          lb_we;

  // ---- stage 0: coordinate mapping and frame-buffer address ----
  always_comb begin
    sx          = x_pixel[9:1];
    sy          = y_pixel[9:1];
    nx          = ({1'b0, sx} >= 10'(SRC_W - 1)) ? 10'(SRC_W - 1) : {1'b0, sx} + 10'd1;
    ny          = ({1'b0, sy} >= 10'(SRC_H - 1)) ? 10'(SRC_H - 1) : {1'b0, sy} + 10'd1;
    in_win      = ({1'b0, x_pixel} < 11'(DST_W)) && ({1'b0, y_pixel} < 11'(DST_H));
    frame_start = de && (x_pixel == 10'd0) && (y_pixel == 10'd0);
    // The frame-start pixel already runs in the newly requested mode.
    mode_d      = frame_start ? mode : mode_q;
    row         = (mode_d && y_pixel[0]) ? ny : {1'b0, sy};
    col         = (mode_d && x_pixel[0]) ? nx : {1'b0, sx};
    src_addr    = AW'(int'(row) * SRC_W + int'(col));
    lb_raddr    = x_pixel[XW-1:0];
  end

  // Line buffer: the read is issued in stage 0 so its data meets src_data in stage 1.
  always_ff @(posedge clk_25MHz) begin
    if (lb_we) lbuf[x_p1_q] <= h_val;
    if (in_win) lb_rd_q <= lbuf[lb_raddr];
  end

  // ---- stage 1: horizontal then vertical interpolation ----
  always_comb begin
    h_val     = xodd_p1_q ? avg2(held_q, src_data) : src_data;
    if (!mode_p1_q)     v_val = src_data;
    else if (!yodd_p1_q) v_val = h_val;
    else                v_val = avg2(lb_rd_q, h_val);
    held_d    = (de_p1_q && !xodd_p1_q) ? src_data : held_q;
    lb_we     = mode_p1_q && !yodd_p1_q && win_p1_q && de_p1_q;
    pix_out_d = (de_p1_q && win_p1_q) ? v_val : '0;
  end

  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      mode_q    <= 1'b0;
      de_p1_q   <= 1'b0;
      win_p1_q  <= 1'b0;
      xodd_p1_q <= 1'b0;
      yodd_p1_q <= 1'b0;
      mode_p1_q <= 1'b0;
      x_p1_q    <= '0;
      held_q    <= '0;
      pix_out_q <= '0;
      pix_de_q  <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      de_p1_q   <= de;
      win_p1_q  <= in_win;
      xodd_p1_q <= x_pixel[0];
      yodd_p1_q <= y_pixel[0];
      mode_p1_q <= mode_d;
      x_p1_q    <= x_pixel[XW-1:0];
      held_q    <= held_d;
      // ---- stage 2: output register ----
      pix_out_q <= pix_out_d;
      pix_de_q  <= de_p1_q;
    end
  end

  assign pix_out = pix_out_q;
  assign pix_de  = pix_de_q;

endmodule
